// File: rtl/fp_exc_pkg.sv
// Shared constants and trap-FSM state type for the FP exception status unit.
`timescale 1ns/1ps
package fp_exc_pkg;

    localparam int FLAG_W  = 5;

    localparam int FLG_OVF = 4;
    localparam int FLG_UNF = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_INV = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ACKED = 2'b10
    } trap_state_t;

    function automatic logic any_set(input logic [FLAG_W-1:0] v);
        return |v;
    endfunction

endpackage

// File: rtl/fp_exc_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment restarts at one.
`timescale 1ns/1ps
module fp_exc_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fp_exception_status_unit.sv
// Sticky FP exception status, per-flag event counters and a maskable trap
// request with req/ack handshake to the controlling sequencer.
`timescale 1ns/1ps
module fp_exception_status_unit
    import fp_exc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flags_valid,
    input  logic [FLAG_W-1:0]    flags,
    input  logic                 mask_wr,
    input  logic [FLAG_W-1:0]    mask_in,
    input  logic                 clr_wr,
    input  logic [FLAG_W-1:0]    clr_bits,
    input  logic [2:0]           cnt_sel,
    output logic [FLAG_W-1:0]    status,
    output logic [FLAG_W-1:0]    trap_mask,
    output logic                 trap_req,
    output logic [FLAG_W-1:0]    trap_cause,
    input  logic                 trap_ack,
    output logic [CNT_WIDTH-1:0] cnt_out
);

    trap_state_t          state, state_next;
    logic [FLAG_W-1:0]    set_vec, clr_vec;
    logic [FLAG_W-1:0]    status_next, mask_next, cause_next;
    logic [CNT_WIDTH-1:0] cnt_arr [FLAG_W];

    assign set_vec     = flags & {FLAG_W{flags_valid}};
    assign clr_vec     = clr_bits & {FLAG_W{clr_wr}};
    assign status_next = (status & ~clr_vec) | set_vec;
    assign mask_next   = mask_wr ? mask_in : trap_mask;

    // The trap decision looks at next-cycle status/mask so trap_req rises together with status.
    always_comb begin
        state_next = state;
        cause_next = trap_cause;
        case (state)
            IDLE: begin
                if (any_set(status_next & mask_next)) begin
                    state_next = REQ;
                    cause_next = status_next & mask_next;
                end
            end
            REQ: begin
                cause_next = trap_cause | (set_vec & trap_mask);
                if (trap_ack) begin
                    state_next = ACKED;
                end
            end
            ACKED: begin
                if (!any_set(status_next & trap_cause)) begin
                    state_next = IDLE;
                    cause_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cause_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            status     <= '0;
            trap_mask  <= '0;
            trap_cause <= '0;
        end else begin
            state      <= state_next;
            status     <= status_next;
            trap_mask  <= mask_next;
            trap_cause <= cause_next;
        end
    end

    assign trap_req = (state == REQ);

    for (genvar i = 0; i < FLAG_W; i++) begin : g_cnt
        fp_exc_sat_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .inc  (set_vec[i]),
            .clr  (clr_vec[i]),
            .count(cnt_arr[i])
        );
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < FLAG_W; i++) begin
            if (cnt_sel == 3'(i)) begin
                cnt_out = cnt_arr[i];
            end
        end
    end

endmodule
